// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters (fetch, data), the arbiter and a shared single-port SRAM.
// The slave modport is the arbiter's view; the master modport is the requester/SRAM side.
interface mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [15:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic [3:0]  sram_w_en;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack, sram_w_en, sram_addr, sram_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, sram_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack, sram_w_en, sram_addr, sram_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving an instruction-fetch port and a data port shared access to one
// single-port SRAM; every access takes three cycles from grant to ack.
module mem_arbiter (
    input logic          sysclk,
    input logic          sysrst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        ISSUE_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        last_grant_r;      // 1'b1 = data port was granted last
    logic        grant_i_s;
    logic        grant_d_s;
    logic        if_elig_s;
    logic        dm_elig_s;
    logic [3:0]  sram_w_en_r;
    logic [15:0] sram_addr_r;
    logic [31:0] sram_wdata_r;
    logic [31:0] if_rdata_r;
    logic [31:0] dm_rdata_r;
    logic        if_ack_r;
    logic        dm_ack_r;
    logic        busy_r;

    // State register
    always_ff @(posedge sysclk or negedge sysrst) begin
        if (!sysrst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Eligibility, arbitration and next-state logic
    always_comb begin
        state_next_s = state_r;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        // A port being acked this cycle still holds req for the finished access; ignore it.
        if_elig_s    = bus.if_req & ~if_ack_r;
        dm_elig_s    = bus.dm_req & ~dm_ack_r;
        case (state_r)
            IDLE: begin
                if (if_elig_s && dm_elig_s) begin
                    if (last_grant_r) begin
                        grant_i_s = 1'b1;
                    end else begin
                        grant_d_s = 1'b1;
                    end
                end else if (if_elig_s) begin
                    grant_i_s = 1'b1;
                end else if (dm_elig_s) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_i_s = 1'b0;
                end
                if (grant_i_s) begin
                    state_next_s = ISSUE_I;
                end else if (grant_d_s) begin
                    state_next_s = ISSUE_D;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE_I: state_next_s = RESP_I;
            ISSUE_D: state_next_s = RESP_D;
            RESP_I:  state_next_s = IDLE;
            RESP_D:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Request latching, SRAM drive, response capture and ack pulses
    always_ff @(posedge sysclk or negedge sysrst) begin
        if (!sysrst) begin
            last_grant_r <= 1'b1;
            sram_w_en_r  <= 4'b0000;
            sram_addr_r  <= 16'h0000;
            sram_wdata_r <= 32'h0000_0000;
            if_rdata_r   <= 32'h0000_0000;
            dm_rdata_r   <= 32'h0000_0000;
            if_ack_r     <= 1'b0;
            dm_ack_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            if_ack_r <= (state_r == RESP_I);
            dm_ack_r <= (state_r == RESP_D);
            busy_r   <= (state_next_s != IDLE);
            // Write enables are loaded only when entering ISSUE_D, so they are live for that cycle alone.
            if (grant_i_s) begin
                sram_addr_r  <= bus.if_addr;
                sram_w_en_r  <= 4'b0000;
                last_grant_r <= 1'b0;
            end else if (grant_d_s) begin
                sram_addr_r  <= bus.dm_addr;
                sram_wdata_r <= bus.dm_wdata;
                sram_w_en_r  <= bus.dm_we;
                last_grant_r <= 1'b1;
            end else begin
                sram_w_en_r  <= 4'b0000;
            end
            if (state_r == RESP_I) begin
                if_rdata_r <= bus.sram_rdata;
            end
            if (state_r == RESP_D) begin
                dm_rdata_r <= bus.sram_rdata;
            end
        end
    end

    assign bus.sram_w_en  = sram_w_en_r;
    assign bus.sram_addr  = sram_addr_r;
    assign bus.sram_wdata = sram_wdata_r;
    assign bus.if_rdata   = if_rdata_r;
    assign bus.dm_rdata   = dm_rdata_r;
    assign bus.if_ack     = if_ack_r;
    assign bus.dm_ack     = dm_ack_r;
    assign bus.busy       = busy_r;
endmodule
